// File: rtl/kernel_accumulator.sv
// Adder-layer accumulator: restores exact |if - w| per kernel lane, sums each beat,
// accumulates beats into one pixel and emits the saturated negative total.
module kernel_accumulator #(
  parameter int NBIT  = 8,
  parameter int NKER  = 9,
  parameter int ACC_W = 20
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  input  logic                     i_last,
  input  logic [NKER*NBIT-1:0]     i_result,
  input  logic [NKER-1:0]          i_sign,
  output logic                     o_valid,
  output logic signed [ACC_W-1:0]  o_data,
  output logic                     o_ovf
);

  localparam int BS_W  = NBIT + $clog2(NKER) + 1;
  localparam int SUM_W = ((ACC_W > BS_W) ? ACC_W : BS_W) + 1;
  localparam logic [SUM_W-1:0] SAT = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};

  // Clamp a non-negative running sum to the largest magnitude the signed output can negate.
  function automatic logic [ACC_W-2:0] saturate(input logic [SUM_W-1:0] val);
    if (val > SAT) saturate = SAT[ACC_W-2:0];
    else           saturate = val[ACC_W-2:0];
  endfunction

  function automatic logic signed [ACC_W-1:0] negate(input logic [ACC_W-2:0] mag);
    negate = -$signed({1'b0, mag});
  endfunction

  logic [BS_W-1:0]  beat_sum_p1_d, beat_sum_p1_q;
  logic             vld_p1_q, last_p1_q;
  logic [ACC_W-2:0] acc_p2_d, acc_p2_q;
  logic             ovf_p2_d, ovf_p2_q;
  logic             o_valid_d, o_ovf_d;
  logic signed [ACC_W-1:0] o_data_d;
  logic [SUM_W-1:0] nxt;
  logic             sat_now;
  logic [ACC_W-2:0] nxt_sat;

  // Stage 1: lane correction (+sign undoes the upstream ones' complement) and beat sum
  always_comb begin
    beat_sum_p1_d = '0;
    for (int k = 0; k < NKER; k++) begin
      beat_sum_p1_d = beat_sum_p1_d + BS_W'(i_result[k*NBIT +: NBIT]) + BS_W'(i_sign[k]);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      beat_sum_p1_q <= '0;
      vld_p1_q      <= 1'b0;
      last_p1_q     <= 1'b0;
    end else begin
      vld_p1_q  <= i_valid;
      last_p1_q <= i_valid & i_last;
      if (i_valid) beat_sum_p1_q <= beat_sum_p1_d;
    end
  end

  // Stage 2: accumulate with saturation; a last beat emits and starts a fresh pixel
  always_comb begin
    nxt       = SUM_W'(acc_p2_q) + SUM_W'(beat_sum_p1_q);
    sat_now   = (nxt > SAT);
    nxt_sat   = saturate(nxt);
    acc_p2_d  = acc_p2_q;
    ovf_p2_d  = ovf_p2_q;
    o_valid_d = 1'b0;
    o_data_d  = o_data;
    o_ovf_d   = o_ovf;
    if (vld_p1_q) begin
      if (last_p1_q) begin
        o_valid_d = 1'b1;
        o_data_d  = negate(nxt_sat);
        o_ovf_d   = ovf_p2_q | sat_now;
        acc_p2_d  = '0;
        ovf_p2_d  = 1'b0;
      end else begin
        acc_p2_d = nxt_sat;
        ovf_p2_d = ovf_p2_q | sat_now;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_p2_q <= '0;
      ovf_p2_q <= 1'b0;
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_ovf    <= 1'b0;
    end else begin
      acc_p2_q <= acc_p2_d;
      ovf_p2_q <= ovf_p2_d;
      o_valid  <= o_valid_d;
      o_data   <= o_data_d;
      o_ovf    <= o_ovf_d;
    end
  end

endmodule
